// File: rtl/ssd_scan4.sv
// Four-digit multiplexed seven-segment scan driver with per-frame input snapshot and dead-time.
// Optional macro SSD_LZ_BLANK_EN enables leading-zero suppression on digits 3..1.
module ssd_scan4 #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in0,
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  input  logic [3:0] in3,
  input  logic [3:0] dp_mask,
  output logic [7:0] seg,
  output logic [3:0] ssd_ctl
);

  localparam int unsigned   CW        = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0][3:0]  snap_q, snap_d;
  logic [3:0]       sdp_q, sdp_d;
  logic [7:0]       seg_q, seg_d;
  logic [3:0]       ctl_q, ctl_d;

  logic             slot_end;
  logic             blank;
  logic [6:0]       seg7;
  logic [3:0]       lead_zero;

  // Segment pattern for bits [6:0] only; the decimal point is merged separately.
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h3F;
    endcase
  endfunction

  // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
  always_comb begin
    slot_end = (cnt_q == CNT_LAST);
    cnt_d    = slot_end ? '0 : cnt_q + CW'(1);
    idx_d    = slot_end ? idx_q + 2'd1 : idx_q;

    // Snapshot only at the very end of the digit-3 slot so a frame never mixes old and new digits.
    snap_d = snap_q;
    sdp_d  = sdp_q;
    if (slot_end && (idx_q == 2'd3)) begin
      snap_d = {in3, in2, in1, in0};
      sdp_d  = dp_mask;
    end

    lead_zero = 4'b0000;
`ifdef SSD_LZ_BLANK_EN
    lead_zero[3] = (snap_q[3] == 4'd0);
    lead_zero[2] = lead_zero[3] && (snap_q[2] == 4'd0);
    lead_zero[1] = lead_zero[2] && (snap_q[1] == 4'd0);
`endif
    seg7 = lead_zero[idx_q] ? 7'h7F : decode(snap_q[idx_q]);

    blank = (BLANK_CYC != 0) && (cnt_q < BLANK_END);
    if (blank) begin
      seg_d = 8'hFF;
      ctl_d = 4'hF;
    end else begin
      seg_d = {~sdp_q[idx_q], seg7};
      ctl_d = ~(4'b0001 << idx_q);
    end
  end

  // NOTE: sequential state uses non-blocking assignments; the small snapshot bank is
  // flops rather than a RAM, so it is reset to give a defined all-zero first frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      idx_q  <= 2'd0;
      snap_q <= '0;
      sdp_q  <= 4'b0000;
      seg_q  <= 8'hFF;
      ctl_q  <= 4'hF;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      sdp_q  <= sdp_d;
      seg_q  <= seg_d;
      ctl_q  <= ctl_d;
    end
  end

  assign seg     = seg_q;
  assign ssd_ctl = ctl_q;

endmodule

// File: tb/tb_ssd_scan4.sv
// Scoreboard bench for ssd_scan4: a cycle-count reference model pushes expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_ssd_scan4;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FR = 4 * SD;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] in0, in1, in2, in3, dp_mask;
  logic [7:0] seg;
  logic [3:0] ssd_ctl;

  always #5 clk = ~clk;

  ssd_scan4 #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in0     (in0),
    .in1     (in1),
    .in2     (in2),
    .in3     (in3),
    .dp_mask (dp_mask),
    .seg     (seg),
    .ssd_ctl (ssd_ctl)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] seg;
    logic [3:0] ctl;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Full 8-bit patterns with dp unlit; dash for 10..15.
  function automatic logic [7:0] ref_pattern(input logic [3:0] d, input logic dp, input bit sup);
    logic [7:0] tbl [16];
    logic [7:0] p;
    tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
            8'h80, 8'h90, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};
    p = sup ? 8'hFF : tbl[d];
    if (dp) p[7] = 1'b0;
    return p;
  endfunction

  // Reference model: position in the frame is derived from a plain cycle count since reset.
  int         m_cyc = 0;
  logic [3:0] m_snap [4] = '{default: 4'd0};
  logic [3:0] m_dp = 4'd0;
  int         m_pos, m_slot, m_within;
  bit         m_sup;
  exp_t       m_e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc  = 0;
      m_snap = '{default: 4'd0};
      m_dp   = 4'd0;
    end else begin
      m_pos    = m_cyc % FR;
      m_slot   = m_pos / SD;
      m_within = m_pos % SD;
      if (m_within < BC) begin
        m_e.seg = 8'hFF;
        m_e.ctl = 4'hF;
      end else begin
        m_e.ctl         = 4'hF;
        m_e.ctl[m_slot] = 1'b0;
        m_sup = 1'b0;
`ifdef SSD_LZ_BLANK_EN
        if (m_slot > 0) begin
          m_sup = 1'b1;
          for (int j = m_slot; j < 4; j++)
            if (m_snap[j] != 4'd0) m_sup = 1'b0;
        end
`endif
        m_e.seg = ref_pattern(m_snap[m_slot], m_dp[m_slot], m_sup);
      end
      sb_q.push_back(m_e);
      if (m_pos == FR - 1) begin
        m_snap = '{in0, in1, in2, in3};
        m_dp   = dp_mask;
      end
      m_cyc++;
    end
  end

  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      check("ctl_onehot0", 32'($countones(~ssd_ctl) <= 1), 32'd1);
      check("sb_depth", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        check("seg", 32'(seg), 32'(mon_e.seg));
        check("ssd_ctl", 32'(ssd_ctl), 32'(mon_e.ctl));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_digits(input logic [3:0] d3, d2, d1, d0, input logic [3:0] dp);
    in3 = d3; in2 = d2; in1 = d1; in0 = d0; dp_mask = dp;
  endtask

  initial begin
    set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000);

    cycles(3);
    check("rst_seg", 32'(seg), 32'hFF);
    check("rst_ctl", 32'(ssd_ctl), 32'hF);
    #1 rst_n = 1'b1;

    // Snapshot: change mid-frame 0, visible from frame 1; in0 change mid-frame 1 appears in frame 2.
    cycles(10);
    set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000);
    cycles(36);
    in0 = 4'd9;
    cycles(FR + 18);

    // Invalid code with decimal point.
    set_digits(4'd0, 4'd0, 4'hC, 4'd0, 4'b0010);
    cycles(2 * FR);

    // Leading-zero patterns.
    set_digits(4'd0, 4'd0, 4'd0, 4'd7, 4'b0000);
    cycles(2 * FR);
    set_digits(4'd0, 4'd1, 4'd0, 4'd0, 4'b0000);
    cycles(2 * FR);

    // Randomized inputs changing at arbitrary points in the frame.
    for (int i = 0; i < 25; i++) begin
      set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)));
      cycles($urandom_range(1, 40));
    end

    // Asynchronous reset while digit 2 is driven.
    set_digits(4'd5, 4'd6, 4'd7, 4'd8, 4'b1111);
    cycles(2 * FR);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ssd_ctl == 4'b1011) break;
    end
    check("wait_1011", 32'(ssd_ctl), 32'b1011);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_seg", 32'(seg), 32'hFF);
    check("async_rst_ctl", 32'(ssd_ctl), 32'hF);
    cycles(2);
    check("rst_hold_seg", 32'(seg), 32'hFF);
    check("rst_hold_ctl", 32'(ssd_ctl), 32'hF);
    #1 rst_n = 1'b1;
    cycles(2 * FR + 5);

    @(negedge clk);
    #1;
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
